// File: rtl/behav_counter_rtl.sv
// Loadable up/down modulo counter with programmable step, prescaler and a
// stretched wrap pulse. Single clock domain, synchronous active-high clear.
module behav_counter_rtl #(
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned KEEP_WIDTH = 1,
   parameter int unsigned HDR_WIDTH  = 1
) (
   input  logic       clk,
   input  logic       clear,
   input  logic [7:0] d,
   input  logic       load,
   input  logic [7:0] load_b,
   input  logic       up_down,
   output logic [7:0] qd,
   output logic       qd_b,
   output logic       qd_c
);

   localparam logic [7:0] Step   = 8'(DATA_WIDTH);
   localparam logic [7:0] PreMax = 8'(HDR_WIDTH - 1);
   localparam logic [4:0] Keep   = 5'(KEEP_WIDTH);

   logic [7:0] qd_q, qd_d;
   logic [7:0] presc_q, presc_d;
   logic [4:0] stretch_q, stretch_d;
   logic       advance;
   logic       wrap;
   logic [8:0] sum;

   always_comb begin
      advance   = (presc_q == PreMax);
      presc_d   = advance ? 8'd0 : presc_q + 8'd1;
      qd_d      = qd_q;
      wrap      = 1'b0;
      sum       = {1'b0, qd_q} + {1'b0, Step};
      stretch_d = (stretch_q != 5'd0) ? stretch_q - 5'd1 : 5'd0;

      if (load) begin
         // Load wins over counting but leaves a running qd_c window alone.
         qd_d    = d;
         presc_d = 8'd0;
      end else if (advance) begin
         if (up_down) begin
            // 9-bit compare so qd+step overflowing 8 bits still wraps.
            if (sum > {1'b0, load_b}) begin
               qd_d = 8'd0;
               wrap = 1'b1;
            end else begin
               qd_d = sum[7:0];
            end
         end else begin
            if (qd_q < Step) begin
               qd_d = load_b;
               wrap = 1'b1;
            end else begin
               qd_d = qd_q - Step;
            end
         end
      end

      if (wrap) begin
         stretch_d = Keep;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         qd_q      <= 8'd0;
         presc_q   <= 8'd0;
         stretch_q <= 5'd0;
      end else begin
         qd_q      <= qd_d;
         presc_q   <= presc_d;
         stretch_q <= stretch_d;
      end
   end

   assign qd   = qd_q;
   assign qd_b = up_down ? (qd_q == load_b) : (qd_q == 8'd0);
   assign qd_c = (stretch_q != 5'd0);

endmodule

// File: tb/tb_behav_counter_rtl.sv
// Directed table-driven bench: default-parameter instance plus a
// step=3 / keep=4 / prescale=2 instance for multi-cycle corners.
module tb_behav_counter_rtl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Default instance
   logic       clear0 = 1'b1, load0 = 1'b0, ud0 = 1'b0;
   logic [7:0] d0 = 8'd0, m0 = 8'd5;
   logic [7:0] qd0;
   logic       qdb0, qdc0;

   // Step 3, keep 4, prescale 2, M=10, counting up
   logic       clear1 = 1'b1, load1 = 1'b0, ud1 = 1'b1;
   logic [7:0] d1 = 8'd0, m1 = 8'd10;
   logic [7:0] qd1;
   logic       qdb1, qdc1;

   behav_counter_rtl u_dut0 (
      .clk     (clk),
      .clear   (clear0),
      .d       (d0),
      .load    (load0),
      .load_b  (m0),
      .up_down (ud0),
      .qd      (qd0),
      .qd_b    (qdb0),
      .qd_c    (qdc0)
   );

   behav_counter_rtl #(
      .DATA_WIDTH (3),
      .KEEP_WIDTH (4),
      .HDR_WIDTH  (2)
   ) u_dut1 (
      .clk     (clk),
      .clear   (clear1),
      .d       (d1),
      .load    (load1),
      .load_b  (m1),
      .up_down (ud1),
      .qd      (qd1),
      .qd_b    (qdb1),
      .qd_c    (qdc1)
   );

   typedef struct {
      logic       clear;
      logic       load;
      logic [7:0] d;
      logic [7:0] m;
      logic       ud;
      logic [7:0] exp_qd;
      logic       exp_b;
      logic       exp_c;
   } vec0_t;

   typedef struct {
      logic       clear;
      logic       load;
      logic [7:0] d;
      logic [7:0] exp_qd;
      logic       exp_c;
   } vec1_t;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int idx, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got 0x%02h expected 0x%02h", name, idx, act, exp);
      end
   endtask

   vec0_t v0[29];
   vec1_t v1[20];

   initial begin
      //           clr  ld   d      m      ud    qd     b     c
      v0[0]  = '{1'b1, 1'b0, 8'h00, 8'd5,  1'b0, 8'd0,  1'b1, 1'b0};
      v0[1]  = '{1'b1, 1'b0, 8'h00, 8'd5,  1'b1, 8'd0,  1'b0, 1'b0};
      v0[2]  = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b1, 8'd1,  1'b0, 1'b0};
      v0[3]  = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b1, 8'd2,  1'b0, 1'b0};
      v0[4]  = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b1, 8'd3,  1'b0, 1'b0};
      v0[5]  = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b1, 8'd4,  1'b0, 1'b0};
      v0[6]  = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b1, 8'd5,  1'b1, 1'b0};
      v0[7]  = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b1, 8'd0,  1'b0, 1'b1};
      v0[8]  = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b1, 8'd1,  1'b0, 1'b0};
      v0[9]  = '{1'b0, 1'b1, 8'h02, 8'd5,  1'b0, 8'd2,  1'b0, 1'b0};
      v0[10] = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b0, 8'd1,  1'b0, 1'b0};
      v0[11] = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b0, 8'd0,  1'b1, 1'b0};
      v0[12] = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b0, 8'd5,  1'b0, 1'b1};
      v0[13] = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b0, 8'd4,  1'b0, 1'b0};
      v0[14] = '{1'b1, 1'b1, 8'h33, 8'd5,  1'b0, 8'd0,  1'b1, 1'b0};
      v0[15] = '{1'b0, 1'b1, 8'h05, 8'd5,  1'b1, 8'd5,  1'b1, 1'b0};
      // Load on the cycle that would otherwise wrap: no pulse.
      v0[16] = '{1'b0, 1'b1, 8'h33, 8'd5,  1'b1, 8'h33, 1'b0, 1'b0};
      v0[17] = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b1, 8'd0,  1'b0, 1'b1};
      v0[18] = '{1'b0, 1'b1, 8'h33, 8'd5,  1'b0, 8'h33, 1'b0, 1'b0};
      v0[19] = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b0, 8'h32, 1'b0, 1'b0};
      v0[20] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      v0[21] = '{1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1};
      v0[22] = '{1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h01, 1'b0, 1'b0};
      v0[23] = '{1'b0, 1'b1, 8'h00, 8'd0,  1'b1, 8'd0,  1'b1, 1'b0};
      v0[24] = '{1'b0, 1'b0, 8'h00, 8'd0,  1'b1, 8'd0,  1'b1, 1'b1};
      v0[25] = '{1'b0, 1'b0, 8'h00, 8'd0,  1'b1, 8'd0,  1'b1, 1'b1};
      v0[26] = '{1'b0, 1'b0, 8'h00, 8'd0,  1'b0, 8'd0,  1'b1, 1'b1};
      v0[27] = '{1'b1, 1'b0, 8'h00, 8'd0,  1'b0, 8'd0,  1'b1, 1'b0};
      v0[28] = '{1'b0, 1'b0, 8'h00, 8'd5,  1'b1, 8'd1,  1'b0, 1'b0};

      //           clr  ld    d      qd    c
      v1[0]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
      v1[1]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0};
      v1[2]  = '{1'b0, 1'b0, 8'd0, 8'd3, 1'b0};
      v1[3]  = '{1'b0, 1'b0, 8'd0, 8'd3, 1'b0};
      v1[4]  = '{1'b0, 1'b0, 8'd0, 8'd6, 1'b0};
      v1[5]  = '{1'b0, 1'b0, 8'd0, 8'd6, 1'b0};
      v1[6]  = '{1'b0, 1'b0, 8'd0, 8'd9, 1'b0};
      v1[7]  = '{1'b0, 1'b0, 8'd0, 8'd9, 1'b0};
      v1[8]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b1};
      v1[9]  = '{1'b0, 1'b1, 8'd9, 8'd9, 1'b1};
      v1[10] = '{1'b0, 1'b0, 8'd0, 8'd9, 1'b1};
      // Re-wrap mid-pulse restarts the 4-cycle window.
      v1[11] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b1};
      v1[12] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b1};
      v1[13] = '{1'b0, 1'b0, 8'd0, 8'd3, 1'b1};
      v1[14] = '{1'b0, 1'b0, 8'd0, 8'd3, 1'b1};
      v1[15] = '{1'b0, 1'b0, 8'd0, 8'd6, 1'b0};
      v1[16] = '{1'b0, 1'b1, 8'd9, 8'd9, 1'b0};
      v1[17] = '{1'b0, 1'b0, 8'd0, 8'd9, 1'b0};
      v1[18] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b1};
      v1[19] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0};

      for (int i = 0; i < 29; i++) begin
         clear0 = v0[i].clear;
         load0  = v0[i].load;
         d0     = v0[i].d;
         m0     = v0[i].m;
         ud0    = v0[i].ud;
         @(posedge clk);
         #1;
         chk("qd", i, qd0, v0[i].exp_qd);
         chk("qd_b", i, {7'd0, qdb0}, {7'd0, v0[i].exp_b});
         chk("qd_c", i, {7'd0, qdc0}, {7'd0, v0[i].exp_c});
      end

      for (int i = 0; i < 20; i++) begin
         clear1 = v1[i].clear;
         load1  = v1[i].load;
         d1     = v1[i].d;
         @(posedge clk);
         #1;
         chk("s3_qd", i, qd1, v1[i].exp_qd);
         chk("s3_qd_c", i, {7'd0, qdc1}, {7'd0, v1[i].exp_c});
      end
      // Up-counting with qd=0 and M=10 is not terminal.
      chk("s3_qd_b", 0, {7'd0, qdb1}, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
